pulse_train_generator: RTL and testbench
========================================

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the phase-length inputs and counters.
REQ-003 Parameter NUM_W, default 8, SHALL set the width of the pulse-count input and counter.
REQ-004 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 Port `start`, input, 1 bit: request to begin a burst; sampled only in IDLE.
REQ-007 Port `abort`, input, 1 bit: terminates an active burst.
REQ-008 Port `high_cycles`, input, CNT_W bits: HIGH phase length in clocks.
REQ-009 Port `low_cycles`, input, CNT_W bits: LOW phase length in clocks.
REQ-010 Port `num_pulses`, input, NUM_W bits: number of pulses in the burst.
REQ-011 Port `pulse_out`, output, 1 bit: generated waveform, registered.
REQ-012 Port `rise_strobe`, output, 1 bit: high in the first cycle of each HIGH phase.
REQ-013 Port `fall_strobe`, output, 1 bit: high in the first cycle after each HIGH phase ends.
REQ-014 Port `busy`, output, 1 bit: registered; high while the FSM is in HIGH or LOW.
REQ-015 Port `done`, output, 1 bit: registered; one-cycle pulse on normal burst completion.
REQ-016 Port `pulses_sent`, output, NUM_W bits: count of completed HIGH phases in the current or last burst.

Function
REQ-017 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-018 In IDLE, `start`=1 SHALL latch `high_cycles`, `low_cycles` and `num_pulses`, and clear `pulses_sent`; inputs SHALL be ignored at all other times.
REQ-019 A latched phase length of 0 SHALL be treated as 1.
REQ-020 A `start` with `num_pulses`=0 SHALL stay in IDLE, assert `done` the next cycle and produce no pulse.
REQ-021 With `start` accepted at edge N, `pulse_out` and `busy` SHALL be 1 from cycle N+1 (one-cycle latency).
REQ-022 HIGH SHALL last exactly `high_cycles` clocks, then `pulses_sent` SHALL increment.
REQ-023 After HIGH, if `pulses_sent` (post-increment) < `num_pulses`, the FSM SHALL enter LOW for exactly `low_cycles` clocks, then return to HIGH.
REQ-024 After the last HIGH, the FSM SHALL enter IDLE directly, with no trailing LOW phase.
REQ-025 In that same cycle, `pulse_out` SHALL fall, `busy` SHALL be 0 and `done` SHALL be 1.
REQ-026 `rise_strobe` SHALL equal `pulse_out` AND NOT previous `pulse_out`.
REQ-027 `fall_strobe` SHALL equal NOT `pulse_out` AND previous `pulse_out`.
REQ-028 The previous-`pulse_out` register SHALL clear on reset.
REQ-029 `abort` in HIGH or LOW SHALL take the FSM to IDLE at the next edge, with `pulse_out`=0 and `busy`=0; `done` SHALL NOT assert, and `pulses_sent` SHALL hold.
REQ-030 `abort` SHALL have priority over `start`; `abort` in IDLE SHALL have no effect.
REQ-031 `start` in the cycle `done`=1 (FSM already in IDLE) SHALL be accepted, giving back-to-back bursts.
REQ-032 Phase counters SHALL count down from the latched length to 1, with no wrap-around.
REQ-033 The maximum length of 2^CNT_W-1 SHALL be supported exactly.

Reset
REQ-034 While `reset`=1 at an edge, the FSM SHALL enter IDLE, and `pulse_out`, `busy`, `done`, `pulses_sent` and all counters SHALL become 0.
REQ-035 `rise_strobe` and `fall_strobe` SHALL be 0 at the next cycle.
REQ-036 Reset SHALL override `start` and `abort`, including mid-burst, with no `done` pulse.

Verification
REQ-037 Nominal burst: `high_cycles`=3, `low_cycles`=2, `num_pulses`=2, start at edge 0 -> `pulse_out`=1 in cycles 1-3 and 6-8, 0 in cycles 4-5 and 9; `rise_strobe` in cycles 1 and 6; `fall_strobe` in cycles 4 and 9; `busy` in cycles 1-8; `done` only in cycle 9; `pulses_sent`=2.
REQ-038 Zero handling: `high_cycles`=0, `low_cycles`=0, `num_pulses`=3 -> 1-high/1-low pattern 101010 followed by `done`. Separately, `num_pulses`=0 -> no pulse, `done` in the next cycle.
REQ-039 Abort: in the nominal case, assert `abort` in cycle 5 -> `pulse_out`=0 and `busy`=0 from cycle 6, `done` never asserts, `pulses_sent`=1. A simultaneous `start` is ignored.
REQ-040 Back-to-back: `start` held continuously with `high_cycles`=1, `low_cycles`=1, `num_pulses`=1 -> a pulse every 2 cycles, with `done` coincident with each `fall_strobe`.
REQ-041 Reset mid-HIGH: `reset` in cycle 2 of the nominal burst -> all outputs 0 next cycle, no `done`. A following `start` behaves as in REQ-037.
REQ-042 Config stability: change `high_cycles` during a burst -> burst timing unchanged.

Source files
------------

// File: rtl/pulse_train_generator.sv
// Burst pulse-train generator: emits num_pulses HIGH phases of high_cycles clocks
// separated by LOW phases of low_cycles clocks, with edge strobes and completion flag.
module pulse_train_generator #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             pulse_out,
   output logic             rise_strobe,
   output logic             fall_strobe,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] pulses_sent
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HIGH = 2'b01,
      ST_LOW  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_W-1:0] NUM_ZERO = {NUM_W{1'b0}};
   localparam logic [NUM_W-1:0] NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [CNT_W-1:0] high_len_r, high_len_s;
   logic [CNT_W-1:0] low_len_r, low_len_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [NUM_W-1:0] num_r, num_s;
   logic [NUM_W-1:0] sent_r, sent_s, sent_inc_s;
   logic             pulse_r, pulse_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             rise_r, fall_r;

   // A zero phase length behaves as a single clock.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
      return (len == CNT_ZERO) ? CNT_ONE : len;
   endfunction

   // Next-state, counter and output decode.
   always_comb begin
      state_s    = state_r;
      high_len_s = high_len_r;
      low_len_s  = low_len_r;
      cnt_s      = cnt_r;
      num_s      = num_r;
      sent_s     = sent_r;
      done_s     = 1'b0;
      sent_inc_s = sent_r + NUM_ONE;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               high_len_s = clamp_len(high_cycles);
               low_len_s  = clamp_len(low_cycles);
               num_s      = num_pulses;
               sent_s     = NUM_ZERO;
               if (num_pulses == NUM_ZERO) begin
                  done_s = 1'b1;
               end else begin
                  state_s = ST_HIGH;
                  cnt_s   = clamp_len(high_cycles);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HIGH: begin
            if (abort) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_ONE) begin
               sent_s = sent_inc_s;
               // Last pulse returns straight to IDLE, no trailing LOW.
               if (sent_inc_s < num_r) begin
                  state_s = ST_LOW;
                  cnt_s   = low_len_r;
               end else begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
                  done_s  = 1'b1;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_LOW: begin
            if (abort) begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_ONE) begin
               state_s = ST_HIGH;
               cnt_s   = high_len_r;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
      pulse_s = (state_s == ST_HIGH);
      busy_s  = (state_s != ST_IDLE);
   end

   // State, configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         high_len_r <= CNT_ZERO;
         low_len_r  <= CNT_ZERO;
         cnt_r      <= CNT_ZERO;
         num_r      <= NUM_ZERO;
         sent_r     <= NUM_ZERO;
         pulse_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         rise_r     <= 1'b0;
         fall_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         high_len_r <= high_len_s;
         low_len_r  <= low_len_s;
         cnt_r      <= cnt_s;
         num_r      <= num_s;
         sent_r     <= sent_s;
         pulse_r    <= pulse_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         rise_r     <= pulse_s & ~pulse_r;
         fall_r     <= ~pulse_s & pulse_r;
      end
   end

   assign pulse_out   = pulse_r;
   assign rise_strobe = rise_r;
   assign fall_strobe = fall_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign pulses_sent = sent_r;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: arithmetic burst model compared
// every cycle, plus literal expectations for the nominal and zero-length bursts.
module tb_pulse_train_generator;

   localparam int CNT_W = 4;
   localparam int NUM_W = 8;

   logic             clk = 1'b0;
   logic             reset, start, abort;
   logic [CNT_W-1:0] high_cycles, low_cycles;
   logic [NUM_W-1:0] num_pulses;
   logic             pulse_out, rise_strobe, fall_strobe, busy, done;
   logic [NUM_W-1:0] pulses_sent;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   pulse_train_generator #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .high_cycles(high_cycles), .low_cycles(low_cycles), .num_pulses(num_pulses),
      .pulse_out(pulse_out), .rise_strobe(rise_strobe), .fall_strobe(fall_strobe),
      .busy(busy), .done(done), .pulses_sent(pulses_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      n_total++;
      if (got != exp) $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, got, exp);
      else n_pass++;
   endtask

   // Burst model: position t within the burst decides the waveform arithmetically.
   bit m_act, m_was;
   int m_t, m_T, m_P, m_H, m_L, m_N, m_off;
   int e_sent;
   bit e_pulse, e_busy, e_done, e_rise, e_fall;

   always @(posedge clk) begin
      cyc++;
      e_done = 1'b0;
      m_was  = e_pulse;
      if (reset) begin
         m_act = 1'b0; e_sent = 0; m_was = 1'b0;
      end else if (m_act) begin
         if (abort) m_act = 1'b0;
         else begin
            m_t++;
            if (m_t > m_T) begin m_act = 1'b0; e_sent = m_N; e_done = 1'b1; end
         end
      end else if (start) begin
         m_H = (high_cycles == 0) ? 1 : int'(high_cycles);
         m_L = (low_cycles == 0) ? 1 : int'(low_cycles);
         m_N = int'(num_pulses);
         m_P = m_H + m_L;
         e_sent = 0;
         if (m_N == 0) e_done = 1'b1;
         else begin m_act = 1'b1; m_t = 1; m_T = m_N * m_H + (m_N - 1) * m_L; end
      end
      if (m_act) begin
         m_off   = (m_t - 1) % m_P;
         e_pulse = (m_off < m_H);
         e_sent  = (m_t - 1) / m_P + ((m_off >= m_H) ? 1 : 0);
      end else begin
         e_pulse = 1'b0;
      end
      e_busy = m_act;
      e_rise = e_pulse && !m_was;
      e_fall = !e_pulse && m_was;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pulse_out", int'(pulse_out), int'(e_pulse));
         chk("rise_strobe", int'(rise_strobe), int'(e_rise));
         chk("fall_strobe", int'(fall_strobe), int'(e_fall));
         chk("busy", int'(busy), int'(e_busy));
         chk("done", int'(done), int'(e_done));
         chk("pulses_sent", int'(pulses_sent), e_sent);
      end
   end

   // Drives start for one cycle; returns during cycle 1 of the burst.
   task automatic start_burst(input int h, input int l, input int n);
      @(negedge clk);
      high_cycles = CNT_W'(h); low_cycles = CNT_W'(l); num_pulses = NUM_W'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [9:0] cp, cr, cf, cb, cd;
   int         sent9;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      high_cycles = 4'd0; low_cycles = 4'd0; num_pulses = 8'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_pulse", int'(pulse_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sent", int'(pulses_sent), 0);
      reset = 1'b0;
      @(negedge clk);

      // Nominal burst captured against literal waveforms.
      cp = 10'd0; cr = 10'd0; cf = 10'd0; cb = 10'd0; cd = 10'd0; sent9 = 0;
      start_burst(3, 2, 2);
      for (int c = 1; c <= 9; c++) begin
         cp[c] = pulse_out; cr[c] = rise_strobe; cf[c] = fall_strobe;
         cb[c] = busy; cd[c] = done;
         if (c == 9) sent9 = int'(pulses_sent);
         @(negedge clk);
      end
      chk("nom_pulse", int'(cp), int'(10'b0111001110));
      chk("nom_rise", int'(cr), int'(10'b0001000010));
      chk("nom_fall", int'(cf), int'(10'b1000010000));
      chk("nom_busy", int'(cb), int'(10'b0111111110));
      chk("nom_done", int'(cd), int'(10'b1000000000));
      chk("nom_sent", sent9, 2);
      repeat (2) @(negedge clk);

      // Zero phase lengths: 101010 then done.
      cp = 10'd0; cd = 10'd0;
      start_burst(0, 0, 3);
      for (int c = 1; c <= 6; c++) begin
         cp[c] = pulse_out; cd[c] = done;
         @(negedge clk);
      end
      chk("zero_pulse", int'(cp), int'(10'b0000101010));
      chk("zero_done", int'(cd), int'(10'b0001000000));
      start_burst(5, 5, 0);
      chk("np0_done", int'(done), 1);
      chk("np0_pulse", int'(pulse_out), 0);
      repeat (3) @(negedge clk);

      // Abort in cycle 5 with a simultaneous start.
      start_burst(3, 2, 2);
      repeat (4) @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_sent", int'(pulses_sent), 1);
      repeat (6) @(negedge clk);

      // Back-to-back single-cycle bursts with start held.
      @(negedge clk);
      high_cycles = 4'd1; low_cycles = 4'd1; num_pulses = 8'd1; start = 1'b1;
      repeat (10) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in cycle 2 of a nominal burst, then a clean nominal burst.
      start_burst(3, 2, 2);
      @(negedge clk);
      reset = 1'b1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      chk("rst_mid_pulse", int'(pulse_out), 0);
      chk("rst_mid_done", int'(done), 0);
      start_burst(3, 2, 2);
      repeat (12) @(negedge clk);

      // Config changed mid-burst must not disturb timing.
      start_burst(3, 2, 2);
      high_cycles = 4'd7; low_cycles = 4'd9; num_pulses = 8'd5;
      repeat (12) @(negedge clk);

      // Maximum phase length.
      start_burst(15, 0, 2);
      repeat (35) @(negedge clk);
      start_burst(15, 15, 3);
      repeat (80) @(negedge clk);

      // Abort while idle has no effect.
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      start_burst(2, 3, 4);
      repeat (25) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
